demux_rr_ctrl: RTL and testbench
================================

# demux_rr_ctrl

Sequencing controller for the team's 1-to-4 demultiplexer. It accepts a valid/ready input word stream and steers each word to one of four output channels. Routing is either fixed, from a select input, or round-robin in packets of PKT_LEN words. A one-word holding register decouples input from output and sustains one word per cycle under back-pressure. The block sits between a single producer and four consumers, in place of the free-running combinational demux.

## Interface
- WIDTH, 1: data word width.
- PKT_LEN, 4: words per channel before the round-robin pointer advances; legal range 1..255.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  enable; gates input acceptance only.
- mode  in  1  0 = fixed routing via sel, 1 = round-robin.
- sel  in  2  fixed-mode channel (sel[1] = MSB).
- in_valid  in  1  producer has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  4  one-hot channel valid; all-zero when nothing is held.
- out_ready  in  4  per-channel consumer ready.
- out_data  out  WIDTH  held word; forced to 0 when no out_valid bit is set.
- cur_ch  out  2  round-robin pointer (next RR destination).
- pkt_done  out  1  one-cycle pulse after the last word of an RR packet is delivered.

## Operation
- Internal state: hold_valid, hold_data, hold_ch[1:0], hold_last, rr_ptr[1:0] (drives cur_ch), word_cnt[7:0], pkt_done register.
- A word is accepted when in_valid && in_ready. A word is delivered when hold_valid && out_ready[hold_ch].
- in_ready = en && (!hold_valid || out_ready[hold_ch]). This is combinational from out_ready, so the same-cycle deliver-and-accept path gives full throughput.
- On accept, the controller captures hold_data = in_data and hold_valid = 1.
- Fixed mode (mode=0): hold_ch = sel sampled at accept, hold_last = 0, word_cnt forced to 0, rr_ptr unchanged.
- RR mode (mode=1): hold_ch = rr_ptr.
  - If word_cnt == PKT_LEN-1: hold_last = 1, word_cnt → 0, rr_ptr → rr_ptr+1 mod 4 (3 wraps to 0).
  - Otherwise: hold_last = 0, word_cnt increments.
- Delivery without a simultaneous accept clears hold_valid. Delivery with a simultaneous accept replaces the held word.
- pkt_done is registered high for exactly one cycle after a delivery with hold_last = 1.
- out_valid[k] = hold_valid && (hold_ch == k). It is never multi-hot.
- en low: in_ready = 0. A held word is still delivered. word_cnt and rr_ptr are retained, so the packet resumes on the same channel when en returns.
- A mode or sel change affects only subsequently accepted words. A switch to fixed mode clears word_cnt, so a partial RR packet is abandoned and the next RR word starts a full packet on the unchanged rr_ptr.
- Two-state FSM (EMPTY, FULL) equivalent to hold_valid:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on deliver without accept.
  - FULL stays FULL on accept, or on no deliver.

## Timing
- Reset, applied when rst_n is low at a clock edge, takes priority over everything and discards any held word:
  - out_valid = 4'b0000, out_data = 0, in_ready = 0, cur_ch = 0, pkt_done = 0, word_cnt = 0.
- Latency: a word accepted at edge N is on out_valid/out_data in the cycle after edge N.
- A word is held indefinitely while out_ready[hold_ch] = 0. Ready bits of other channels are ignored.
- Throughput: one word per cycle while the destination is ready.
- pkt_done asserts in the cycle after the delivering edge.

## Structure
- Package demux_ctrl_pkg holds:
  - NUM_CH = 4, CH_W = 2.
  - Mode encodings MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - FSM state typedef {EMPTY, FULL}.
- One sub-module, ch_decode, provides the 2-bit → 4-bit one-hot decoder with a valid gate. It drives out_valid from hold_ch and hold_valid.

## Test plan
- Reset mid-stream: hold a word on ch2 with out_ready = 0, assert rst_n = 0 for one edge → out_valid = 0000, cur_ch = 0, in_ready = 0, word discarded.
- Fixed mode, sel = 2'b10, all ready, send 3 words A, B, C → out_valid = 0100 for 3 consecutive cycles with data A, B, C; cur_ch stays 0; no pkt_done.
- RR mode, PKT_LEN = 4, all ready, stream 16 words → channels 0,0,0,0,1,1,1,1,2,…,3; pkt_done pulses 4 times; cur_ch wraps to 0.
- Back-pressure: RR on ch1, out_ready[1] = 0 for 5 cycles while out_ready[0] = 1 → in_ready = 0, word held, out_valid = 0010. Releasing the stall delivers the word in that cycle, and a new word is accepted in the same cycle.
- en drop: RR, PKT_LEN = 4, after 2 words on ch0 drop en for 3 cycles, then resume → 2 more words go to ch0, then ch1; word_cnt preserved.
- Mode switch: RR after 2 words on ch3, switch to fixed with sel = 0 for 1 word, then back to RR → the fixed word goes to ch0; the next 4 words go to ch3 and pkt_done fires after the 4th.

Source files
------------

// File: rtl/demux_rr_ctrl_pkg.sv
// Shared constants and types for the demux sequencing controller.
package demux_ctrl_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/demux_rr_ctrl_if.sv
// Producer-side and consumer-side handshake bundle for the demux controller.
interface demux_rr_ctrl_if #(parameter int WIDTH = 1);
  import demux_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [WIDTH-1:0]  out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/demux_rr_ctrl_ch_decode.sv
// Channel index to one-hot valid decoder, gated by a valid bit.
module ch_decode
  import demux_ctrl_pkg::*;
(
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_ch,
  output logic [NUM_CH-1:0] o_onehot
);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign o_onehot[k] = i_valid && (i_ch == CH_W'(k));
  end
endmodule

// File: rtl/demux_rr_ctrl.sv
// 1-to-4 demux controller: one-word holding register, fixed or round-robin
// packet routing, full throughput via combinational ready pass-through.
module demux_rr_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int PKT_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_mode,
  input  logic [CH_W-1:0] i_sel,
  output logic [CH_W-1:0] o_cur_ch,
  output logic            o_pkt_done,
  demux_rr_ctrl_if.slave  bus
);
  localparam logic [7:0] LAST_CNT = 8'(PKT_LEN - 1);

  state_t            r_state;
  logic [WIDTH-1:0]  r_hold_data;
  logic [CH_W-1:0]   r_hold_ch;
  logic              r_hold_last;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [7:0]        r_word_cnt;
  logic              r_pkt_done;

  logic              w_hold_valid;
  logic              w_dst_ready;
  logic              w_deliver;
  logic              w_in_ready;
  logic              w_accept;
  logic [NUM_CH-1:0] w_out_valid;

  assign w_hold_valid = (r_state == FULL);
  assign w_dst_ready  = bus.out_ready[r_hold_ch];
  assign w_deliver    = w_hold_valid && w_dst_ready;
  // Ready is held low while reset is asserted so nothing is accepted into a clearing register.
  assign w_in_ready   = rst_n && i_en && (!w_hold_valid || w_dst_ready);
  assign w_accept     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_hold_data <= '0;
      r_hold_ch   <= '0;
      r_hold_last <= 1'b0;
      r_rr_ptr    <= '0;
      r_word_cnt  <= '0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done <= w_deliver && r_hold_last;
      if (w_accept) begin
        r_state     <= FULL;
        r_hold_data <= bus.in_data;
        if (i_mode == MODE_FIXED) begin
          // Fixed words abandon any partial RR packet; rr_ptr is left alone.
          r_hold_ch   <= i_sel;
          r_hold_last <= 1'b0;
          r_word_cnt  <= '0;
        end else begin
          r_hold_ch <= r_rr_ptr;
          if (r_word_cnt == LAST_CNT) begin
            r_hold_last <= 1'b1;
            r_word_cnt  <= '0;
            r_rr_ptr    <= r_rr_ptr + 2'd1;
          end else begin
            r_hold_last <= 1'b0;
            r_word_cnt  <= r_word_cnt + 8'd1;
          end
        end
      end else if (w_deliver) begin
        r_state <= EMPTY;
      end
    end
  end

  ch_decode u_ch_decode (
    .i_valid  (w_hold_valid),
    .i_ch     (r_hold_ch),
    .o_onehot (w_out_valid)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_hold_valid ? r_hold_data : '0;
  assign o_cur_ch      = r_rr_ptr;
  assign o_pkt_done    = r_pkt_done;
endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed self-checking bench for demux_rr_ctrl (WIDTH=8, PKT_LEN=4).
module tb_demux_rr_ctrl;
  localparam int WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic [1:0] cur_ch;
  logic       pkt_done;
  int         checks;
  int         errors;

  demux_rr_ctrl_if #(.WIDTH(WIDTH)) bus ();

  demux_rr_ctrl #(.WIDTH(WIDTH), .PKT_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_sel      (sel),
    .o_cur_ch   (cur_ch),
    .o_pkt_done (pkt_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; mode = 1'b0; sel = 2'b10;
    bus.out_ready = 4'b0000; bus.in_data = 8'h00; bus.in_valid = 1'b0;
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL reset_pre_hold got %b exp 0100", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h5A) begin errors++; $display("FAIL reset_pre_data got %h exp 5a", bus.out_data); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_discard got %b exp 0000", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_fixed();
    logic [7:0] words [3];
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    do_reset();
    mode = 1'b0; sel = 2'b10; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = words[i];
      step();
      checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("FAIL fixed_valid[%0d] got %b exp 0100", i, bus.out_valid); end
      checks++; if (bus.out_data !== words[i]) begin errors++; $display("FAIL fixed_data[%0d] got %h exp %h", i, bus.out_data, words[i]); end
      checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL fixed_cur_ch[%0d] got %0d exp 0", i, cur_ch); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL fixed_pkt_done[%0d] got %b exp 0", i, pkt_done); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL fixed_drain got %b exp 0000", bus.out_valid); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL fixed_drain_pkt_done got %b exp 0", pkt_done); end
  endtask

  task automatic test_rr();
    int pulses;
    logic [3:0] exp_v;
    logic exp_pd;
    pulses = 0;
    do_reset();
    mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'h10 + 8'(i);
      step();
      exp_v = 4'b0001 << (i / 4);
      exp_pd = (i > 0) && (((i - 1) % 4) == 3);
      if (pkt_done === 1'b1) pulses++;
      checks++; if (bus.out_valid !== exp_v) begin errors++; $display("FAIL rr_valid[%0d] got %b exp %b", i, bus.out_valid, exp_v); end
      checks++; if (bus.out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, bus.out_data, 8'h10 + 8'(i)); end
      checks++; if (pkt_done !== exp_pd) begin errors++; $display("FAIL rr_pkt_done[%0d] got %b exp %b", i, pkt_done, exp_pd); end
      checks++; if (cur_ch !== 2'(((i + 1) / 4) % 4)) begin errors++; $display("FAIL rr_cur_ch[%0d] got %0d exp %0d", i, cur_ch, ((i + 1) / 4) % 4); end
    end
    bus.in_valid = 1'b0;
    step();
    if (pkt_done === 1'b1) pulses++;
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL rr_last_pkt_done got %b exp 1", pkt_done); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL rr_pulse_count got %0d exp 4", pulses); end
    step();
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rr_pkt_done_width got %b exp 0", pkt_done); end
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL rr_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h30 + 8'(i);
      step();
    end
    bus.out_ready = 4'b0001; bus.in_data = 8'h40;
    step();
    checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL bp_ch1_valid got %b exp 0010", bus.out_valid); end
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL bp_pkt_done got %b exp 1", pkt_done); end
    bus.in_data = 8'h41;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 0010", i, bus.out_valid); end
      checks++; if (bus.out_data !== 8'h40) begin errors++; $display("FAIL bp_hold_data[%0d] got %h exp 40", i, bus.out_data); end
      step();
    end
    bus.out_ready = 4'b0010;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL bp_next_valid got %b exp 0010", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h41) begin errors++; $display("FAIL bp_next_data got %h exp 41", bus.out_data); end
    bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    step();
    checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b exp 0000", bus.out_valid); end
  endtask

  task automatic test_en_drop();
    do_reset();
    mode = 1'b1; en = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    bus.in_data = 8'h60; step();
    bus.in_data = 8'h61; step();
    checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h61) begin errors++; $display("FAIL en_pre got %b/%h exp 0001/61", bus.out_valid, bus.out_data); end
    en = 1'b0; bus.in_data = 8'h62;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready got %b exp 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL en_idle_valid[%0d] got %b exp 0000", i, bus.out_valid); end
      checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL en_idle_cur_ch[%0d] got %0d exp 0", i, cur_ch); end
    end
    en = 1'b1;
    step();
    checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h62) begin errors++; $display("FAIL en_resume0 got %b/%h exp 0001/62", bus.out_valid, bus.out_data); end
    bus.in_data = 8'h63; step();
    checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h63) begin errors++; $display("FAIL en_resume1 got %b/%h exp 0001/63", bus.out_valid, bus.out_data); end
    checks++; if (cur_ch !== 2'd1) begin errors++; $display("FAIL en_cur_ch got %0d exp 1", cur_ch); end
    bus.in_data = 8'h64; step();
    checks++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 8'h64) begin errors++; $display("FAIL en_next_ch got %b/%h exp 0010/64", bus.out_valid, bus.out_data); end
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL en_pkt_done got %b exp 1", pkt_done); end
    bus.in_valid = 1'b0; step();
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; bus.out_ready = 4'b1111; bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = 8'(i); step();
    end
    bus.in_data = 8'h70; step();
    bus.in_data = 8'h71; step();
    checks++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 8'h71) begin errors++; $display("FAIL ms_rr_pre got %b/%h exp 1000/71", bus.out_valid, bus.out_data); end
    mode = 1'b0; sel = 2'b00; bus.in_data = 8'h72; step();
    checks++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 8'h72) begin errors++; $display("FAIL ms_fixed got %b/%h exp 0001/72", bus.out_valid, bus.out_data); end
    checks++; if (cur_ch !== 2'd3) begin errors++; $display("FAIL ms_fixed_cur_ch got %0d exp 3", cur_ch); end
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'h73 + 8'(i); step();
      checks++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 8'h73 + 8'(i)) begin errors++; $display("FAIL ms_rr[%0d] got %b/%h exp 1000/%h", i, bus.out_valid, bus.out_data, 8'h73 + 8'(i)); end
      checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL ms_rr_pkt_done[%0d] got %b exp 0", i, pkt_done); end
    end
    checks++; if (cur_ch !== 2'd0) begin errors++; $display("FAIL ms_cur_ch_wrap got %0d exp 0", cur_ch); end
    bus.in_valid = 1'b0; step();
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL ms_pkt_done got %b exp 1", pkt_done); end
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'b00;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 4'b0000;
    test_reset();
    test_fixed();
    test_rr();
    test_back_to_back();
    test_en_drop();
    test_mode_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
